cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Parametrised run-control unit for the single-cycle MIPS core. Sequences CPU reset,
//  then gates core clock-enable in free-run, bounded-cycle or single-step mode.
//  Stops on halt, breakpoint, cycle limit or abort, and reports a cycle count and stop cause.
//  Sits between the top-level clk/areset and the core's reset/clock-enable inputs.
// PARAMETERS
//  RESET_CYCLES  2   cycles cpu_rst_n is held low after areset release or soft_rst (>=1)
//  CNT_W         16  width of cycle counter and cycle_limit
//  PC_W          32  width of pc_in / bp_addr
// PORTS
//  clk          in   1      system clock, rising edge
//  areset       in   1      asynchronous, active-low reset
//  soft_rst     in   1      synchronous pulse: re-enter HOLD from any state
//  start        in   1      pulse: begin run in selected mode (IDLE/STOPPED only)
//  mode         in   2      00 free-run, 01 bounded, 10 single-step, 11 treated as 00
//  cycle_limit  in   CNT_W  bounded-mode cycle budget, sampled on accepted start
//  step         in   1      pulse: one core cycle in single-step mode
//  abort        in   1      stop request, any active state
//  halt_in      in   1      core halt indication
//  bp_en        in   1      breakpoint enable
//  bp_addr      in   PC_W   breakpoint PC
//  pc_in        in   PC_W   core's current PC
//  cpu_rst_n    out  1      registered active-low reset to core
//  cpu_clk_en   out  1      core clock enable (combinational from state + inputs)
//  running      out  1      state is RUN or STEP
//  done         out  1      state is STOPPED
//  stop_cause   out  3      0 none, 1 halt, 2 break, 3 limit, 4 abort
//  cycle_count  out  CNT_W  enabled core cycles since last accepted start
// BEHAVIOUR
//  areset=0: state=HOLD, hold counter=0, cpu_rst_n=0, cycle_count=0, stop_cause=0,
//    limit and mode registers=0; all outputs low.
//  FSM states: HOLD, IDLE, RUN, STEP, STOPPED.
//  HOLD: cpu_rst_n=0 while the counter counts RESET_CYCLES clocks; then ->IDLE and
//    cpu_rst_n=1 from that edge. soft_rst in any state -> HOLD, counter cleared.
//  IDLE/STOPPED + start: latch mode and cycle_limit, clear cycle_count and stop_cause;
//    ->RUN (mode 00/01/11) or ->STEP (10). start ignored in HOLD/RUN/STEP.
//  stop_cond is evaluated each cycle in RUN and STEP, priority:
//    abort > halt_in > (bp_en && pc_in==bp_addr && !bp_skip) > (bounded && cycle_count==limit).
//  RUN: cpu_clk_en = !stop_cond. STEP: cpu_clk_en = step && !stop_cond.
//  Active stop_cond: no enable that cycle; ->STOPPED next edge; stop_cause latched.
//  STEP with step=0 and no stop_cond: remain in STEP.
//  Breakpoint stops before the instruction at bp_addr executes.
//  bp_skip: set on a start accepted from STOPPED with stop_cause=break; cleared after the
//    first enabled cycle. Resume therefore executes past the breakpoint.
//  cycle_count increments on every cycle with cpu_clk_en=1; it saturates at all-ones.
//    Free-run never stops on saturation.
//  Bounded with cycle_limit=0: stops on the first RUN cycle with zero enables, cause=limit.
//  Bounded with step=1 is irrelevant; step is ignored outside STEP.
//  areset mid-run: immediate return to HOLD with reset values; cpu_clk_en drops asynchronously.
//  All other outputs change only on rising clk edges.
// TESTING
//  1 Release areset, RESET_CYCLES=2 -> cpu_rst_n low for 2 edges, high on the 3rd;
//    state IDLE, cpu_clk_en=0.
//  2 mode=01, limit=5, start -> exactly 5 cpu_clk_en cycles, then done=1,
//    stop_cause=3, cycle_count=5.
//  3 Free-run; halt_in rises after 7 enables -> no enable that cycle, cause=1,
//    count=7; abort+halt together -> cause=4.
//  4 bp_en, bp_addr=0x0C, PC steps 0,4,8,C -> 3 enables, cause=2; restart ->
//    first enable at PC 0x0C, run continues past it.
//  5 mode=10: step pulses at gaps of 3 cycles, 4 pulses -> exactly 4 enables,
//    count=4, state STEP throughout.
//  6 areset low during RUN at count 3 -> cpu_clk_en=0 at once, cpu_rst_n=0,
//    count=0; soft_rst in STOPPED -> HOLD sequence repeats.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module  : cpu_run_ctrl
// Brief   : Reset sequencing and clock-enable gating (free-run, bounded,
//           single-step) for the single-cycle MIPS core, with stop cause.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int PC_W         = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             soft_rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic             step,
  input  logic             abort,
  input  logic             halt_in,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc_in,
  output logic             cpu_rst_n,
  output logic             cpu_clk_en,
  output logic             running,
  output logic             done,
  output logic [2:0]       stop_cause,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int c_hold_w = $clog2(RESET_CYCLES + 1);
  localparam logic [c_hold_w-1:0] c_hold_cycles = c_hold_w'(RESET_CYCLES);

  localparam logic [2:0] c_cause_none  = 3'd0;
  localparam logic [2:0] c_cause_halt  = 3'd1;
  localparam logic [2:0] c_cause_break = 3'd2;
  localparam logic [2:0] c_cause_limit = 3'd3;
  localparam logic [2:0] c_cause_abort = 3'd4;

  localparam logic [1:0] c_mode_bounded = 2'b01;
  localparam logic [1:0] c_mode_step    = 2'b10;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_IDLE    = 3'd1,
    S_RUN     = 3'd2,
    S_STEP    = 3'd3,
    S_STOPPED = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_hold_w-1:0]   r_hold_cnt;
  logic                  r_cpu_rst_n;
  logic [1:0]            r_mode;
  logic [CNT_W-1:0]      r_limit;
  logic [CNT_W-1:0]      r_count;
  logic [2:0]            r_cause;
  logic                  r_bp_skip;

  logic                  w_active;
  logic                  w_bp_hit;
  logic                  w_limit_hit;
  logic [2:0]            w_stop_cause;
  logic                  w_stop;
  logic                  w_start_ok;
  logic                  w_clk_en;

  assign w_active    = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_bp_hit    = bp_en && (pc_in == bp_addr) && !r_bp_skip;
  assign w_limit_hit = (r_mode == c_mode_bounded) && (r_count == r_limit);
  assign w_start_ok  = start && !soft_rst &&
                       ((r_state == S_IDLE) || (r_state == S_STOPPED));

  always_comb begin
    w_stop_cause = c_cause_none;
    if (abort)            w_stop_cause = c_cause_abort;
    else if (halt_in)     w_stop_cause = c_cause_halt;
    else if (w_bp_hit)    w_stop_cause = c_cause_break;
    else if (w_limit_hit) w_stop_cause = c_cause_limit;
  end

  assign w_stop = w_active && (w_stop_cause != c_cause_none);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) r_state <= S_HOLD;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_clk_en = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_hold_cnt == c_hold_cycles) w_next = S_IDLE;
      end
      S_IDLE, S_STOPPED: begin
        if (start) w_next = (mode == c_mode_step) ? S_STEP : S_RUN;
      end
      S_RUN: begin
        if (w_stop) w_next = S_STOPPED;
        else        w_clk_en = 1'b1;
      end
      S_STEP: begin
        if (w_stop) w_next = S_STOPPED;
        else        w_clk_en = step;
      end
      default: w_next = S_HOLD;
    endcase
    if (soft_rst) w_next = S_HOLD;
  end

  // Counter parks at its terminal value once HOLD has been left.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_hold_cnt  <= '0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_cpu_rst_n <= (w_next != S_HOLD);
      if (soft_rst)
        r_hold_cnt <= '0;
      else if ((r_state == S_HOLD) && (r_hold_cnt != c_hold_cycles))
        r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_mode    <= '0;
      r_limit   <= '0;
      r_count   <= '0;
      r_cause   <= c_cause_none;
      r_bp_skip <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_mode  <= mode;
        r_limit <= cycle_limit;
        r_count <= '0;
        r_cause <= c_cause_none;
      end else begin
        if (w_clk_en && (r_count != {CNT_W{1'b1}}))
          r_count <= r_count + CNT_W'(1);
        if (w_stop && !soft_rst)
          r_cause <= w_stop_cause;
      end

      // Resuming from a breakpoint lets the instruction at bp_addr execute once.
      if (soft_rst)
        r_bp_skip <= 1'b0;
      else if (w_start_ok)
        r_bp_skip <= (r_state == S_STOPPED) && (r_cause == c_cause_break);
      else if (w_clk_en)
        r_bp_skip <= 1'b0;
    end
  end

  assign cpu_rst_n   = r_cpu_rst_n;
  assign cpu_clk_en  = w_clk_en;
  assign running     = w_active;
  assign done        = (r_state == S_STOPPED);
  assign stop_cause  = r_cause;
  assign cycle_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// Module  : tb_cpu_run_ctrl
// Brief   : Directed, table-driven bench for cpu_run_ctrl with a small PC model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

  logic        clk;
  logic        areset;
  logic        soft_rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] cycle_limit;
  logic        step;
  logic        abort;
  logic        halt_in;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_rst_n;
  logic        cpu_clk_en;
  logic        running;
  logic        done;
  logic [2:0]  stop_cause;
  logic [15:0] cycle_count;

  logic        pc_clr;
  logic        abort_force;
  int          halt_at;
  int          abort_at;
  int          en_seen;
  int          n_checks;
  int          n_fail;

  cpu_run_ctrl #(
    .RESET_CYCLES(2),
    .CNT_W       (16),
    .PC_W        (32)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .soft_rst   (soft_rst),
    .start      (start),
    .mode       (mode),
    .cycle_limit(cycle_limit),
    .step       (step),
    .abort      (abort),
    .halt_in    (halt_in),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_in      (pc),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_clk_en (cpu_clk_en),
    .running    (running),
    .done       (done),
    .stop_cause (stop_cause),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: PC advances by one word per enabled cycle.
  always @(posedge clk) begin
    if (pc_clr) begin
      pc      <= 32'h0;
      en_seen <= 0;
    end else if (cpu_clk_en) begin
      pc      <= pc + 32'd4;
      en_seen <= en_seen + 1;
    end
  end

  assign halt_in = (halt_at >= 0) && (en_seen >= halt_at);
  assign abort   = abort_force || ((abort_at >= 0) && (en_seen >= abort_at));

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] limit;
    int          halt_at;
    int          abort_at;
    logic        bp_en;
    logic [31:0] bp_addr;
    int          exp_en;
    logic [2:0]  exp_cause;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_pc();
    pc_clr = 1'b1;
    @(negedge clk);
    pc_clr = 1'b0;
  endtask

  // Called at a negedge; returns at the first negedge in RUN/STEP.
  task automatic do_start(input logic [1:0] m, input logic [15:0] lim);
    mode        = m;
    cycle_limit = lim;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int budget;
    budget = 200;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    areset      = 1'b0;
    soft_rst    = 1'b0;
    start       = 1'b0;
    mode        = 2'b00;
    cycle_limit = 16'd0;
    step        = 1'b0;
    abort_force = 1'b0;
    bp_en       = 1'b0;
    bp_addr     = 32'h0;
    halt_at     = -1;
    abort_at    = -1;
    pc_clr      = 1'b1;

    //            mode   limit   halt abort bp    bp_addr  en cause  count
    vecs[0] = '{2'b01, 16'd5,  -1,  -1, 1'b0, 32'h0,   5, 3'd3, 16'd5};
    vecs[1] = '{2'b00, 16'd0,   7,  -1, 1'b0, 32'h0,   7, 3'd1, 16'd7};
    vecs[2] = '{2'b00, 16'd0,   7,   7, 1'b0, 32'h0,   7, 3'd4, 16'd7};
    vecs[3] = '{2'b11, 16'd0,   3,  -1, 1'b0, 32'h0,   3, 3'd1, 16'd3};
    vecs[4] = '{2'b01, 16'd0,  -1,  -1, 1'b0, 32'h0,   0, 3'd3, 16'd0};
    vecs[5] = '{2'b01, 16'd10,  4,  -1, 1'b0, 32'h0,   4, 3'd1, 16'd4};
    vecs[6] = '{2'b01, 16'd4,   4,  -1, 1'b0, 32'h0,   4, 3'd1, 16'd4};
    vecs[7] = '{2'b00, 16'd0,  -1,  -1, 1'b1, 32'hC,   3, 3'd2, 16'd3};

    // Reset state and release sequence
    repeat (2) @(negedge clk);
    pc_clr = 1'b0;
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_clk_en",    {31'd0, cpu_clk_en}, 32'd0);
    chk("rst_running",   {31'd0, running}, 32'd0);
    chk("rst_done",      {31'd0, done}, 32'd0);
    chk("rst_cause",     {29'd0, stop_cause}, 32'd0);
    chk("rst_count",     {16'd0, cycle_count}, 32'd0);
    areset = 1'b1;
    @(negedge clk);
    chk("rel_edge1_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    chk("rel_edge2_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    chk("rel_edge3_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("rel_idle_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    chk("rel_idle_running", {31'd0, running}, 32'd0);
    chk("rel_idle_done",   {31'd0, done}, 32'd0);

    // Table-driven run scenarios
    for (int i = 0; i < 8; i++) begin
      halt_at  = vecs[i].halt_at;
      abort_at = vecs[i].abort_at;
      bp_en    = vecs[i].bp_en;
      bp_addr  = vecs[i].bp_addr;
      clear_pc();
      do_start(vecs[i].mode, vecs[i].limit);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_enables", i), en_seen, vecs[i].exp_en);
      chk($sformatf("v%0d_cause", i), {29'd0, stop_cause}, {29'd0, vecs[i].exp_cause});
      chk($sformatf("v%0d_count", i), {16'd0, cycle_count}, {16'd0, vecs[i].exp_count});
      chk($sformatf("v%0d_running", i), {31'd0, running}, 32'd0);
    end

    // Resume from breakpoint: first enable happens at the breakpoint PC
    halt_at  = -1;
    abort_at = -1;
    do_start(2'b00, 16'd0);
    chk("bp_resume_pc",     pc, 32'hC);
    chk("bp_resume_clk_en", {31'd0, cpu_clk_en}, 32'd1);
    repeat (4) @(negedge clk);
    chk("bp_resume_running", {31'd0, running}, 32'd1);
    chk("bp_resume_pc_past", pc, 32'h1C);
    chk("bp_resume_count",   {16'd0, cycle_count}, 32'd4);
    abort_force = 1'b1;
    #1 chk("bp_abort_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    @(negedge clk);
    abort_force = 1'b0;
    chk("bp_abort_done",  {31'd0, done}, 32'd1);
    chk("bp_abort_cause", {29'd0, stop_cause}, 32'd4);
    chk("bp_abort_count", {16'd0, cycle_count}, 32'd4);

    // Single-step: four pulses separated by three idle cycles
    bp_en = 1'b0;
    clear_pc();
    do_start(2'b10, 16'd0);
    for (int k = 0; k < 4; k++) begin
      step = 1'b1;
      #1;
      chk($sformatf("step%0d_en", k), {31'd0, cpu_clk_en}, 32'd1);
      chk($sformatf("step%0d_running", k), {31'd0, running}, 32'd1);
      @(negedge clk);
      step = 1'b0;
      for (int g = 0; g < 3; g++) begin
        #1;
        chk($sformatf("step%0d_gap%0d_en", k, g), {31'd0, cpu_clk_en}, 32'd0);
        chk($sformatf("step%0d_gap%0d_running", k, g), {31'd0, running}, 32'd1);
        @(negedge clk);
      end
    end
    chk("step_enables", en_seen, 32'd4);
    chk("step_count",   {16'd0, cycle_count}, 32'd4);
    chk("step_pc",      pc, 32'h10);
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    step    = 1'b1;
    #1 chk("step_bp_blocks_en", {31'd0, cpu_clk_en}, 32'd0);
    @(negedge clk);
    step  = 1'b0;
    bp_en = 1'b0;
    chk("step_bp_done",  {31'd0, done}, 32'd1);
    chk("step_bp_cause", {29'd0, stop_cause}, 32'd2);
    chk("step_bp_count", {16'd0, cycle_count}, 32'd4);

    // Asynchronous reset in the middle of a free run
    clear_pc();
    do_start(2'b00, 16'd0);
    repeat (3) @(negedge clk);
    chk("ar_pre_count", {16'd0, cycle_count}, 32'd3);
    chk("ar_pre_en",    {31'd0, cpu_clk_en}, 32'd1);
    areset = 1'b0;
    #1;
    chk("ar_clk_en",  {31'd0, cpu_clk_en}, 32'd0);
    chk("ar_rst_n",   {31'd0, cpu_rst_n}, 32'd0);
    chk("ar_count",   {16'd0, cycle_count}, 32'd0);
    chk("ar_running", {31'd0, running}, 32'd0);
    @(negedge clk);
    areset = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_hold_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    chk("ar_release_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // soft_rst from STOPPED repeats the hold sequence; start is ignored in HOLD
    clear_pc();
    do_start(2'b01, 16'd2);
    wait_done("sr_pre");
    chk("sr_pre_count", {16'd0, cycle_count}, 32'd2);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    chk("sr_rst_n0", {31'd0, cpu_rst_n}, 32'd0);
    chk("sr_done0",  {31'd0, done}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sr_start_ignored", {31'd0, running}, 32'd0);
    chk("sr_rst_n1", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    chk("sr_rst_n2", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    chk("sr_rst_n3",   {31'd0, cpu_rst_n}, 32'd1);
    chk("sr_idle_done", {31'd0, done}, 32'd0);
    chk("sr_idle_run",  {31'd0, running}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
